// File: rtl/sub_unit_if.sv
// Operand/result bundle for the ripple-borrow subtractor: operands and qualifiers in,
// combinational and registered results out.
interface sub_unit_if #(
  parameter int WIDTH = 4
);
  // in_valid is a pure strobe with no back-pressure: every cycle it is high at a
  // rising edge captures a/b, and out_valid is high for exactly the following cycle.
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             in_valid;
  logic             clr_sticky;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             out_valid;
  logic [WIDTH-1:0] diff_q;
  logic             borrow_q;
  logic             zero_q;
  logic             ovf_q;
  logic             sticky_borrow;

  modport master (
    output a, b, in_valid, clr_sticky,
    input  diff, borrow, out_valid, diff_q, borrow_q, zero_q, ovf_q, sticky_borrow
  );

  modport slave (
    input  a, b, in_valid, clr_sticky,
    output diff, borrow, out_valid, diff_q, borrow_q, zero_q, ovf_q, sticky_borrow
  );
endinterface

// File: rtl/sub_unit.sv
// Unsigned WIDTH-bit subtractor: ripple-borrow chain of per-bit full subtractors,
// plus a one-stage registered copy with valid, zero, signed-overflow and sticky-borrow flags.
module sub_unit #(
  parameter int WIDTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  sub_unit_if.slave  bus
);

  localparam int MSB = WIDTH - 1;

  logic [WIDTH:0]   w_br;
  logic [WIDTH-1:0] w_diff;
  logic             w_zero;
  logic             w_ovf;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_diff_q;
  logic             r_borrow_q;
  logic             r_zero_q;
  logic             r_ovf_q;
  logic             r_sticky;

  assign w_br[0] = 1'b0;

  // One full subtractor per bit; borrow ripples from LSB to MSB.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic w_axb;
    assign w_axb       = bus.a[i] ^ bus.b[i];
    assign w_diff[i]   = w_axb ^ w_br[i];
    assign w_br[i+1]   = (~bus.a[i] & bus.b[i]) | (~w_axb & w_br[i]);
  end

  assign w_zero = (w_diff == '0);
  // Signed overflow only when operand signs differ and the result sign leaves the minuend's.
  assign w_ovf  = (bus.a[MSB] != bus.b[MSB]) & (w_diff[MSB] != bus.a[MSB]);

  assign bus.diff   = w_diff;
  assign bus.borrow = w_br[WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_diff_q    <= '0;
      r_borrow_q  <= 1'b0;
      r_zero_q    <= 1'b0;
      r_ovf_q     <= 1'b0;
      r_sticky    <= 1'b0;
    end else begin
      r_out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_diff_q   <= w_diff;
        r_borrow_q <= w_br[WIDTH];
        r_zero_q   <= w_zero;
        r_ovf_q    <= w_ovf;
      end
      // A borrowing capture wins over a same-cycle clear.
      r_sticky <= (bus.clr_sticky ? 1'b0 : r_sticky) | (bus.in_valid & w_br[WIDTH]);
    end
  end

  assign bus.out_valid     = r_out_valid;
  assign bus.diff_q        = r_diff_q;
  assign bus.borrow_q      = r_borrow_q;
  assign bus.zero_q        = r_zero_q;
  assign bus.ovf_q         = r_ovf_q;
  assign bus.sticky_borrow = r_sticky;

endmodule

// File: tb/tb_sub_unit.sv
// Self-checking bench for sub_unit: directed vector table, reset corner cases,
// exhaustive combinational sweep and randomized traffic against an arithmetic model.
module tb_sub_unit;

  localparam int W = 4;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  sub_unit_if #(.WIDTH(W)) u_if ();

  sub_unit #(.WIDTH(W)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if.slave)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         iv;
    logic         clr;
    logic [W-1:0] e_diff;
    logic         e_br;
    logic [W-1:0] e_diff_q;
    logic         e_br_q;
    logic         e_zero_q;
    logic         e_ovf_q;
    logic         e_ov;
    logic         e_sticky;
  } vec_t;

  vec_t vecs[9];

  // Scoreboard state for the random phase
  logic [W-1:0] exp_q[$];
  logic         m_ov, m_br_q, m_zero_q, m_ovf_q, m_sticky;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic iv, input logic clr);
    u_if.a          = a;
    u_if.b          = b;
    u_if.in_valid   = iv;
    u_if.clr_sticky = clr;
  endtask

  task automatic chk_regs_zero(input string tag);
    chk({tag, "_out_valid"}, 32'(u_if.out_valid), 0);
    chk({tag, "_diff_q"},    32'(u_if.diff_q), 0);
    chk({tag, "_borrow_q"},  32'(u_if.borrow_q), 0);
    chk({tag, "_zero_q"},    32'(u_if.zero_q), 0);
    chk({tag, "_ovf_q"},     32'(u_if.ovf_q), 0);
    chk({tag, "_sticky"},    32'(u_if.sticky_borrow), 0);
  endtask

  // Reference arithmetic, computed from plain integer rules
  function automatic int ref_diff(input int a, input int b);
    return (a - b + (1 << W)) % (1 << W);
  endfunction

  function automatic logic ref_ovf(input int a, input int b);
    int sa, sb, r;
    sa = (a >= (1 << (W - 1))) ? a - (1 << W) : a;
    sb = (b >= (1 << (W - 1))) ? b - (1 << W) : b;
    r  = sa - sb;
    return (r > (1 << (W - 1)) - 1) || (r < -(1 << (W - 1)));
  endfunction

  initial begin
    n_vec = 0;
    n_err = 0;
    vecs[0] = '{4'd6, 4'd3, 1, 0, 4'd3,  0, 4'd3,  0, 0, 0, 1, 0};
    vecs[1] = '{4'd2, 4'd7, 1, 0, 4'd11, 1, 4'd11, 1, 0, 0, 1, 1};
    vecs[2] = '{4'd8, 4'd1, 1, 0, 4'd7,  0, 4'd7,  0, 0, 1, 1, 1};
    vecs[3] = '{4'd5, 4'd5, 1, 0, 4'd0,  0, 4'd0,  0, 1, 0, 1, 1};
    vecs[4] = '{4'd0, 4'd15,1, 0, 4'd1,  1, 4'd1,  1, 0, 0, 1, 1};
    vecs[5] = '{4'd3, 4'd1, 0, 0, 4'd2,  0, 4'd1,  1, 0, 0, 0, 1};
    vecs[6] = '{4'd9, 4'd4, 0, 1, 4'd5,  0, 4'd1,  1, 0, 0, 0, 0};
    vecs[7] = '{4'd1, 4'd2, 1, 1, 4'd15, 1, 4'd15, 1, 0, 0, 1, 1};
    vecs[8] = '{4'd7, 4'd8, 1, 0, 4'd15, 1, 4'd15, 1, 0, 1, 1, 1};

    // Reset state
    rst_n = 1'b0;
    drive('0, '0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1 chk_regs_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table
    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].a, vecs[i].b, vecs[i].iv, vecs[i].clr);
      #1;
      chk($sformatf("v%0d_diff", i),   32'(u_if.diff),   32'(vecs[i].e_diff));
      chk($sformatf("v%0d_borrow", i), 32'(u_if.borrow), 32'(vecs[i].e_br));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_diff_q", i),    32'(u_if.diff_q),        32'(vecs[i].e_diff_q));
      chk($sformatf("v%0d_borrow_q", i),  32'(u_if.borrow_q),      32'(vecs[i].e_br_q));
      chk($sformatf("v%0d_zero_q", i),    32'(u_if.zero_q),        32'(vecs[i].e_zero_q));
      chk($sformatf("v%0d_ovf_q", i),     32'(u_if.ovf_q),         32'(vecs[i].e_ovf_q));
      chk($sformatf("v%0d_out_valid", i), 32'(u_if.out_valid),     32'(vecs[i].e_ov));
      chk($sformatf("v%0d_sticky", i),    32'(u_if.sticky_borrow), 32'(vecs[i].e_sticky));
      @(negedge clk);
    end

    // Asynchronous reset between edges after a capture
    drive(4'd10, 4'd3, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1 chk_regs_zero("async_rst");
    chk("async_rst_diff",   32'(u_if.diff), 32'd7);
    chk("async_rst_borrow", 32'(u_if.borrow), 0);
    drive(4'd3, 4'd10, 1'b1, 1'b0);
    #1;
    chk("rst_comb_diff",   32'(u_if.diff), 32'd9);
    chk("rst_comb_borrow", 32'(u_if.borrow), 1);
    @(posedge clk);
    #1 chk_regs_zero("held_rst");
    @(negedge clk);
    rst_n = 1'b1;
    drive(4'd4, 4'd1, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    chk("post_rst_diff_q",    32'(u_if.diff_q), 32'd3);
    chk("post_rst_out_valid", 32'(u_if.out_valid), 1);
    chk("post_rst_borrow_q",  32'(u_if.borrow_q), 0);
    chk("post_rst_sticky",    32'(u_if.sticky_borrow), 0);
    @(negedge clk);

    // Exhaustive combinational sweep, with X on the qualifiers
    u_if.in_valid   = 1'bx;
    u_if.clr_sticky = 1'bx;
    for (int a = 0; a < (1 << W); a++) begin
      for (int b = 0; b < (1 << W); b++) begin
        u_if.a = W'(a);
        u_if.b = W'(b);
        #1;
        chk($sformatf("sweep_diff_%0d_%0d", a, b),   32'(u_if.diff),   32'(ref_diff(a, b)));
        chk($sformatf("sweep_borrow_%0d_%0d", a, b), 32'(u_if.borrow), 32'(a < b));
      end
    end

    // Randomized traffic against the model
    rst_n = 1'b0;
    drive('0, '0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n    = 1'b1;
    m_ov     = 1'b0;
    m_br_q   = 1'b0;
    m_zero_q = 1'b0;
    m_ovf_q  = 1'b0;
    m_sticky = 1'b0;
    exp_q.push_back('0);
    for (int n = 0; n < 300; n++) begin
      int ra, rb;
      logic riv, rclr, rbr;
      ra   = int'($urandom_range(0, (1 << W) - 1));
      rb   = int'($urandom_range(0, (1 << W) - 1));
      riv  = ($urandom_range(0, 3) != 0);
      rclr = ($urandom_range(0, 7) == 0);
      drive(W'(ra), W'(rb), riv, rclr);
      rbr = (ra < rb);
      #1;
      chk("rnd_diff",   32'(u_if.diff),   32'(ref_diff(ra, rb)));
      chk("rnd_borrow", 32'(u_if.borrow), 32'(rbr));
      if (riv) begin
        void'(exp_q.pop_front());
        exp_q.push_back(W'(ref_diff(ra, rb)));
        m_br_q   = rbr;
        m_zero_q = (ra == rb);
        m_ovf_q  = ref_ovf(ra, rb);
      end
      m_ov     = riv;
      m_sticky = (rclr ? 1'b0 : m_sticky) | (riv & rbr);
      @(posedge clk);
      #1;
      chk("rnd_out_valid", 32'(u_if.out_valid),     32'(m_ov));
      chk("rnd_diff_q",    32'(u_if.diff_q),        32'(exp_q[0]));
      chk("rnd_borrow_q",  32'(u_if.borrow_q),      32'(m_br_q));
      chk("rnd_zero_q",    32'(u_if.zero_q),        32'(m_zero_q));
      chk("rnd_ovf_q",     32'(u_if.ovf_q),         32'(m_ovf_q));
      chk("rnd_sticky",    32'(u_if.sticky_borrow), 32'(m_sticky));
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
